// File: rtl/fan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fan_ctrl : PWM fan driver with tach measurement, spin-up and stall retry  |
// | Optional build macro: FAN_CTRL_RAMP_EN (soft ramp of RUN duty)            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fan_ctrl #(
  parameter int WIN_CNT   = 49999999,
  parameter int SPIN_WIN  = 2,
  parameter int STALL_MIN = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CFG_VLD,
  input  logic [9:0]  CFG_DUTY,
  input  logic        CFG_AUTO,
  input  logic        FAN_IN,
  output logic        PWM,
  output logic [26:0] FAN_CNT,
  output logic        CNT_VLD,
  output logic        STALL,
  output logic [1:0]  STATE
);

  localparam int c_win_w  = (WIN_CNT  < 1) ? 1 : $clog2(WIN_CNT + 1);
  localparam int c_spin_w = (SPIN_WIN < 2) ? 1 : $clog2(SPIN_WIN + 1);
  localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WIN_CNT);
  localparam logic [c_spin_w-1:0] c_spin_last = c_spin_w'((SPIN_WIN < 1) ? 0 : SPIN_WIN - 1);
  localparam logic [26:0]         c_stall_min = 27'(STALL_MIN);
  localparam logic [26:0]         c_acc_max   = '1;
  localparam logic [9:0]          c_duty_full = 10'd1023;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPINUP = 2'd1,
    S_RUN    = 2'd2,
    S_STALL  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_sync;
  logic                w_fall;
  logic [c_win_w-1:0]  r_win_cnt;
  logic                w_tick;
  logic [26:0]         r_acc;
  logic [26:0]         r_fan_cnt;
  logic                r_cnt_vld;
  logic [9:0]          r_pwm_cnt;
  logic [9:0]          r_target;
  logic                r_auto;
  logic                r_stall;
  logic [c_spin_w-1:0] r_spin_cnt;
  logic                w_spin_clr;
  logic                w_spin_inc;
  logic                w_stall_set;
  logic [9:0]          w_run_duty;
  logic [9:0]          w_eff;

  // Idle-high tach line: flops preset to 1 so reset release is not seen as a fall.
  always_ff @(posedge CLK_I) begin
    if (RST_I) r_sync <= 3'b111;
    else       r_sync <= {r_sync[1:0], FAN_IN};
  end

  assign w_fall = r_sync[2] & ~r_sync[1];
  assign w_tick = (r_win_cnt == c_win_last);

  always_ff @(posedge CLK_I) begin
    if (RST_I)       r_win_cnt <= '0;
    else if (w_tick) r_win_cnt <= '0;
    else             r_win_cnt <= r_win_cnt + 1'b1;
  end

  // An edge on the terminal tick seeds the next window instead of the closing one.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_acc     <= '0;
      r_fan_cnt <= '0;
      r_cnt_vld <= 1'b0;
    end else begin
      r_cnt_vld <= w_tick;
      if (w_tick) begin
        r_fan_cnt <= r_acc;
        r_acc     <= {26'd0, w_fall};
      end else if (w_fall && (r_acc != c_acc_max)) begin
        r_acc <= r_acc + 27'd1;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 10'd1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_target <= '0;
      r_auto   <= 1'b0;
    end else if (CFG_VLD) begin
      r_target <= CFG_DUTY;
      r_auto   <= CFG_AUTO;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A configuration write always takes precedence over the window tick.
  always_comb begin
    w_state_nxt = r_state;
    w_spin_clr  = 1'b0;
    w_spin_inc  = 1'b0;
    w_stall_set = 1'b0;
    if (CFG_VLD) begin
      if (CFG_DUTY == 10'd0) begin
        w_state_nxt = S_IDLE;
      end else if (r_state == S_IDLE) begin
        w_state_nxt = S_SPINUP;
        w_spin_clr  = 1'b1;
      end
    end else if (w_tick) begin
      case (r_state)
        S_SPINUP: begin
          if (r_spin_cnt == c_spin_last) w_state_nxt = S_RUN;
          else                           w_spin_inc  = 1'b1;
        end
        S_RUN: begin
          if (r_auto && (r_acc < c_stall_min)) begin
            w_state_nxt = S_STALL;
            w_stall_set = 1'b1;
          end
        end
        S_STALL: begin
          w_state_nxt = S_SPINUP;
          w_spin_clr  = 1'b1;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I)           r_spin_cnt <= '0;
    else if (w_spin_clr) r_spin_cnt <= '0;
    else if (w_spin_inc) r_spin_cnt <= r_spin_cnt + 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I)            r_stall <= 1'b0;
    else if (CFG_VLD)     r_stall <= 1'b0;
    else if (w_stall_set) r_stall <= 1'b1;
  end

`ifdef FAN_CTRL_RAMP_EN
  logic [9:0] r_ramp;

  // Enter RUN at full drive, then walk one step per PWM period toward the target.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_ramp <= '0;
    end else if ((w_state_nxt == S_RUN) && (r_state != S_RUN)) begin
      r_ramp <= c_duty_full;
    end else if ((r_state == S_RUN) && (r_pwm_cnt == 10'd1023)) begin
      if (r_ramp > r_target)      r_ramp <= r_ramp - 10'd1;
      else if (r_ramp < r_target) r_ramp <= r_ramp + 10'd1;
    end
  end

  assign w_run_duty = r_ramp;
`else
  assign w_run_duty = r_target;
`endif

  always_comb begin
    w_eff = 10'd0;
    case (r_state)
      S_SPINUP, S_STALL: w_eff = c_duty_full;
      S_RUN:             w_eff = w_run_duty;
      default:           w_eff = 10'd0;
    endcase
  end

  assign PWM     = (w_eff == c_duty_full) || (r_pwm_cnt < w_eff);
  assign FAN_CNT = r_fan_cnt;
  assign CNT_VLD = r_cnt_vld;
  assign STALL   = r_stall;
  assign STATE   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fan_ctrl : directed self-checking bench for fan_ctrl (WIN_CNT=99)      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fan_ctrl;

  localparam int WIN = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_vld;
  logic [9:0]  cfg_duty;
  logic        cfg_auto;
  logic        fan_in;
  logic        fan_manual;
  logic        tach_en;
  logic        tach_gen = 1'b1;
  int          tcnt = 0;
  logic        pwm;
  logic [26:0] fan_cnt;
  logic        cnt_vld;
  logic        stall;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0] duty;
    logic       auto_en;
    logic [1:0] st;
    int         high;
  } vec_t;
  vec_t vecs [5];

  fan_ctrl #(.WIN_CNT(WIN), .SPIN_WIN(2), .STALL_MIN(1)) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .CFG_VLD (cfg_vld),
    .CFG_DUTY(cfg_duty),
    .CFG_AUTO(cfg_auto),
    .FAN_IN  (fan_in),
    .PWM     (pwm),
    .FAN_CNT (fan_cnt),
    .CNT_VLD (cnt_vld),
    .STALL   (stall),
    .STATE   (state)
  );

  always #5 clk = ~clk;

  assign fan_in = tach_en ? tach_gen : fan_manual;

  // Square wave, period 20 cycles: exactly 5 falling edges per 100-cycle window.
  always @(negedge clk) begin
    if (!tach_en) begin
      tcnt     <= 0;
      tach_gen <= 1'b1;
    end else if (tcnt == 9) begin
      tcnt     <= 0;
      tach_gen <= ~tach_gen;
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic steps_to_vld(output int n, output int high);
    n = 0;
    high = 0;
    do begin
      step();
      n++;
      high += int'(pwm);
    end while (!cnt_vld && n < 400);
    if (!cnt_vld) chk("cnt_vld_seen", 32'(cnt_vld), 1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim);
    int n;
    n = 0;
    while (state !== s && n < lim) begin
      step();
      n++;
    end
    chk("reach_state", 32'(state), 32'(s));
  endtask

  task automatic cfg(input logic [9:0] d, input logic a);
    cfg_vld  = 1'b1;
    cfg_duty = d;
    cfg_auto = a;
    step();
    cfg_vld  = 1'b0;
  endtask

  // Returns at the negedge inside the terminal-tick cycle (window counter at WIN).
  task automatic align_to_tick();
    int n, h;
    steps_to_vld(n, h);
    repeat (WIN) step();
  endtask

  initial begin
    int n, h, cnt;

    vecs[0] = '{duty: 10'd1,    auto_en: 1'b0, st: 2'd2, high: 1};
    vecs[1] = '{duty: 10'd100,  auto_en: 1'b0, st: 2'd2, high: 100};
    vecs[2] = '{duty: 10'd1022, auto_en: 1'b0, st: 2'd2, high: 1022};
    vecs[3] = '{duty: 10'd1023, auto_en: 1'b0, st: 2'd2, high: 1024};
    vecs[4] = '{duty: 10'd512,  auto_en: 1'b1, st: 2'd2, high: 512};

    rst        = 1'b1;
    cfg_vld    = 1'b0;
    cfg_duty   = '0;
    cfg_auto   = 1'b0;
    fan_manual = 1'b1;
    tach_en    = 1'b0;
    repeat (3) step();

    chk("rst_state",   32'(state),   0);
    chk("rst_pwm",     32'(pwm),     0);
    chk("rst_fan_cnt", 32'(fan_cnt), 0);
    chk("rst_cnt_vld", 32'(cnt_vld), 0);
    chk("rst_stall",   32'(stall),   0);

    // Idle: window pulses every 100 cycles, no drive.
    rst = 1'b0;
    steps_to_vld(n, h);
    chk("first_vld_cycles", 32'(n), 100);
    chk("idle_pwm_high_a", 32'(h), 0);
    steps_to_vld(n, h);
    chk("vld_interval", 32'(n), 100);
    chk("idle_pwm_high_b", 32'(h), 0);
    chk("idle_state", 32'(state), 0);
    chk("idle_fan_cnt", 32'(fan_cnt), 0);

    // Spin-up entered exactly on a terminal tick: two full windows at full drive.
    tach_en = 1'b1;
    align_to_tick();
    cfg(10'd512, 1'b1);
    chk("spin_entry_state", 32'(state), 1);
    n = 0;
    cnt = 0;
    while (state == 2'd1 && n < 500) begin
      if (!pwm) cnt++;
      step();
      n++;
    end
    chk("spin_cycles", 32'(n), 200);
    chk("spin_pwm_low", 32'(cnt), 0);
    chk("run_state", 32'(state), 2);
    h = 0;
    repeat (1024) begin
      h += int'(pwm);
      step();
    end
    chk("run_pwm_512", 32'(h), 512);
    steps_to_vld(n, h);
    chk("run_fan_cnt", 32'(fan_cnt), 5);
    chk("run_no_stall", 32'(stall), 0);

    for (int i = 0; i < 5; i++) begin
      cfg(vecs[i].duty, vecs[i].auto_en);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      h = 0;
      repeat (1024) begin
        h += int'(pwm);
        step();
      end
      chk($sformatf("vec%0d_pwm_high", i), 32'(h), 32'(vecs[i].high));
    end

    // Stall detection with auto=1 and a dead tach, then endless retry.
    tach_en = 1'b0;
    wait_state(2'd3, 400);
    chk("stall_flag", 32'(stall), 1);
    chk("stall_cnt_vld", 32'(cnt_vld), 1);
    chk("stall_fan_cnt", 32'(fan_cnt), 0);
    n = 0;
    while (state == 2'd3 && n < 300) begin
      step();
      n++;
    end
    chk("stall_cycles", 32'(n), 100);
    chk("retry_state", 32'(state), 1);
    cnt = 0;
    repeat (400) begin
      if (!stall) cnt++;
      step();
    end
    chk("stall_sticky", 32'(cnt), 0);
    cfg(10'd512, 1'b0);
    chk("stall_clear", 32'(stall), 0);

    // auto=0: RUN holds even with no tach pulses.
    wait_state(2'd2, 400);
    cnt = 0;
    repeat (300) begin
      if (state != 2'd2) cnt++;
      step();
    end
    chk("manual_run_hold", 32'(cnt), 0);

    // Duty 0 written on the terminal tick: IDLE wins, measurement still updates.
    tach_en = 1'b1;
    repeat (3) steps_to_vld(n, h);
    align_to_tick();
    cfg(10'd0, 1'b0);
    chk("off_state", 32'(state), 0);
    chk("off_pwm", 32'(pwm), 0);
    chk("off_cnt_vld", 32'(cnt_vld), 1);
    chk("off_fan_cnt", 32'(fan_cnt), 5);

    // Tach fall detected on the terminal-tick cycle lands in the next window.
    tach_en    = 1'b0;
    fan_manual = 1'b1;
    steps_to_vld(n, h);
    steps_to_vld(n, h);
    repeat (WIN - 2) step();
    fan_manual = 1'b0;
    steps_to_vld(n, h);
    chk("tick_edge_excl", 32'(fan_cnt), 0);
    fan_manual = 1'b1;
    steps_to_vld(n, h);
    chk("tick_edge_next", 32'(fan_cnt), 1);

    // Reset mid-operation from RUN with a non-zero measurement.
    tach_en = 1'b1;
    cfg(10'd300, 1'b1);
    wait_state(2'd2, 400);
    steps_to_vld(n, h);
    chk("pre_rst_fan_cnt", 32'(fan_cnt), 5);
    rst = 1'b1;
    step();
    chk("mid_rst_state",   32'(state),   0);
    chk("mid_rst_pwm",     32'(pwm),     0);
    chk("mid_rst_fan_cnt", 32'(fan_cnt), 0);
    chk("mid_rst_cnt_vld", 32'(cnt_vld), 0);
    chk("mid_rst_stall",   32'(stall),   0);
    rst = 1'b0;
    steps_to_vld(n, h);
    chk("post_rst_vld_cycles", 32'(n), 100);
    chk("post_rst_pwm_high", 32'(h), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
